// File: rtl/mc_control.sv
// Multi-cycle control unit for a 32-bit RISC core with a unified memory port.
// The state is registered; outputs are decoded from that state so FETCH and
// MEM_WR can qualify their strobes with mem_ready in the same cycle. While
// rst is low every output is forced to 0, so a pending request drops at once.
module mc_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ir_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_op,
    output logic [1:0]  result_src,
    output logic        retire,
    output logic [31:0] instret,
    output logic        trap
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_ALU_WB, S_MEM_ADDR, S_MEM_RD,
        S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL, S_LUI, S_ILLEGAL
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] instret_q;
    logic        branch_ok;
    logic        is_rtype;
    logic [3:0]  exec_op;

    // Only BEQ/BNE are implemented; other branch encodings trap.
    assign branch_ok = (funct3[2:1] == 2'b00);
    // opcode bit 5 separates R from I and store from load.
    assign is_rtype  = opcode[5];
    // Only shift-right (funct3 101) takes the funct7 bit on immediates.
    assign exec_op   = is_rtype ? {funct7_5, funct3}
                                : {funct7_5 & (funct3 == 3'b101), funct3};
    assign instret   = instret_q;

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R, OP_I:        state_nxt = S_EXEC;
                    OP_LOAD, OP_STORE: state_nxt = S_MEM_ADDR;
                    OP_BRANCH:         state_nxt = S_BRANCH;
                    OP_JAL:            state_nxt = S_JAL;
                    OP_LUI:            state_nxt = S_LUI;
                    default:           state_nxt = S_ILLEGAL;
                endcase
            end
            S_EXEC:     state_nxt = S_ALU_WB;
            S_ALU_WB:   state_nxt = S_FETCH;
            S_MEM_ADDR: state_nxt = is_rtype ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_nxt = S_MEM_WB;
            S_MEM_WB:   state_nxt = S_FETCH;
            S_MEM_WR:   if (mem_ready) state_nxt = S_FETCH;
            S_BRANCH:   state_nxt = branch_ok ? S_FETCH : S_ILLEGAL;
            S_JAL:      state_nxt = S_FETCH;
            S_LUI:      state_nxt = S_FETCH;
            S_ILLEGAL:  state_nxt = S_ILLEGAL;
            default:    state_nxt = S_FETCH;
        endcase
    end

    // State register and retired-instruction counter (wraps naturally).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_FETCH;
            instret_q <= 32'd0;
        end else begin
            state <= state_nxt;
            if (retire) instret_q <= instret_q + 32'd1;
        end
    end

    // Control decode; everything not named for a state stays 0.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = ALU_ADD;
        result_src = 2'b00;
        retire     = 1'b0;
        trap       = 1'b0;
        if (rst) begin
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b10;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                S_EXEC: begin
                    alu_src_a = 2'b10;
                    alu_src_b = is_rtype ? 2'b00 : 2'b01;
                    alu_op    = exec_op;
                end
                S_ALU_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_MEM_RD: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    result_src = 2'b01;
                    retire     = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    addr_sel = 1'b1;
                    retire   = mem_ready;
                end
                S_BRANCH: begin
                    if (branch_ok) begin
                        alu_src_a = 2'b10;
                        alu_op    = ALU_SUB;
                        pc_write  = alu_zero ^ funct3[0];
                        pc_src    = 1'b1;
                        retire    = 1'b1;
                    end
                end
                S_JAL: begin
                    pc_write   = 1'b1;
                    pc_src     = 1'b1;
                    reg_write  = 1'b1;
                    result_src = 2'b10;
                    retire     = 1'b1;
                end
                S_LUI: begin
                    reg_write  = 1'b1;
                    result_src = 2'b11;
                    retire     = 1'b1;
                end
                S_ILLEGAL: trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: a cycle-by-cycle vector table for the
// normal instruction flows, then hand sequences for wrap, reset and traps.
module tb_mc_control;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7_5 = 1'b0;
    logic        alu_zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, pc_src, ir_write, mem_req, mem_we, addr_sel, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [3:0]  alu_op;
    logic        retire, trap;
    logic [31:0] instret;

    mc_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .result_src(result_src), .retire(retire),
        .instret(instret), .trap(trap)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Bit order: pcw pcs irw mreq mwe asel rw sa[1:0] sb[1:0] op[3:0] rs[1:0] ret trap
    logic [18:0] ctl;
    assign ctl = {pc_write, pc_src, ir_write, mem_req, mem_we, addr_sel, reg_write,
                  alu_src_a, alu_src_b, alu_op, result_src, retire, trap};

    function automatic logic [18:0] cw(input logic pcw, pcs, irw, mreq, mwe, asel, rw,
                                       input logic [1:0] sa, sb, input logic [3:0] op,
                                       input logic [1:0] rs, input logic ret, trp);
        return {pcw, pcs, irw, mreq, mwe, asel, rw, sa, sb, op, rs, ret, trp};
    endfunction

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic        rdy;
        logic [18:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_ret = 0;

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                           ST = 7'b0100011, BR = 7'b1100011, JL = 7'b1101111,
                           LU = 7'b0110111;

    logic [18:0] W_FW, W_FR, W_DEC, W_WB, W_MA, W_MR, W_MWB, W_SW, W_SR,
                 W_JAL, W_LUI, W_TRAP;

    task automatic add(input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, z, rdy, input logic [18:0] exp);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.rdy = rdy; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Apply inputs just after a falling edge, check, then advance one cycle.
    task automatic cyc(input string nm, input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, z, rdy, input logic [18:0] exp);
        opcode = op; funct3 = f3; funct7_5 = f7; alu_zero = z; mem_ready = rdy;
        #1;
        chk(nm, {13'd0, ctl}, {13'd0, exp});
        @(negedge clk);
    endtask

    initial begin
        W_FW   = cw(0,0,0,1,0,0,0, 2'b00,2'b10,4'h0,2'b00,0,0);
        W_FR   = cw(1,0,1,1,0,0,0, 2'b00,2'b10,4'h0,2'b00,0,0);
        W_DEC  = cw(0,0,0,0,0,0,0, 2'b01,2'b01,4'h0,2'b00,0,0);
        W_WB   = cw(0,0,0,0,0,0,1, 2'b00,2'b00,4'h0,2'b00,1,0);
        W_MA   = cw(0,0,0,0,0,0,0, 2'b10,2'b01,4'h0,2'b00,0,0);
        W_MR   = cw(0,0,0,1,0,1,0, 2'b00,2'b00,4'h0,2'b00,0,0);
        W_MWB  = cw(0,0,0,0,0,0,1, 2'b00,2'b00,4'h0,2'b01,1,0);
        W_SW   = cw(0,0,0,1,1,1,0, 2'b00,2'b00,4'h0,2'b00,0,0);
        W_SR   = cw(0,0,0,1,1,1,0, 2'b00,2'b00,4'h0,2'b00,1,0);
        W_JAL  = cw(1,1,0,0,0,0,1, 2'b00,2'b00,4'h0,2'b10,1,0);
        W_LUI  = cw(0,0,0,0,0,0,1, 2'b00,2'b00,4'h0,2'b11,1,0);
        W_TRAP = cw(0,0,0,0,0,0,0, 2'b00,2'b00,4'h0,2'b00,0,1);

        // ADD: 4 cycles, alu_op 0000 in EXEC
        add(R,3'b000,0,0,1,W_FR); add(R,3'b000,0,0,1,W_DEC);
        add(R,3'b000,0,0,1,cw(0,0,0,0,0,0,0,2'b10,2'b00,4'b0000,2'b00,0,0));
        add(R,3'b000,0,0,1,W_WB);
        // SUB
        add(R,3'b000,1,0,1,W_FR); add(R,3'b000,1,0,0,W_DEC);
        add(R,3'b000,1,0,1,cw(0,0,0,0,0,0,0,2'b10,2'b00,4'b1000,2'b00,0,0));
        add(R,3'b000,1,0,1,W_WB);
        // SRAI keeps funct7_5
        add(I,3'b101,1,0,1,W_FR); add(I,3'b101,1,0,1,W_DEC);
        add(I,3'b101,1,0,1,cw(0,0,0,0,0,0,0,2'b10,2'b01,4'b1101,2'b00,0,0));
        add(I,3'b101,1,0,1,W_WB);
        // ADDI with immediate bit 30 set: funct7_5 must be dropped
        add(I,3'b000,1,0,1,W_FR); add(I,3'b000,1,0,1,W_DEC);
        add(I,3'b000,1,0,1,cw(0,0,0,0,0,0,0,2'b10,2'b01,4'b0000,2'b00,0,0));
        add(I,3'b000,1,0,1,W_WB);
        // Load, two wait states in FETCH and in MEM_RD: 9 cycles
        add(LD,3'b010,0,0,0,W_FW); add(LD,3'b010,0,0,0,W_FW); add(LD,3'b010,0,0,1,W_FR);
        add(LD,3'b010,0,0,1,W_DEC); add(LD,3'b010,0,0,1,W_MA);
        add(LD,3'b010,0,0,0,W_MR); add(LD,3'b010,0,0,0,W_MR); add(LD,3'b010,0,0,1,W_MR);
        add(LD,3'b010,0,0,0,W_MWB);
        // Store, one wait state
        add(ST,3'b010,0,0,1,W_FR); add(ST,3'b010,0,0,1,W_DEC); add(ST,3'b010,0,0,1,W_MA);
        add(ST,3'b010,0,0,0,W_SW); add(ST,3'b010,0,0,1,W_SR);
        // BEQ taken, BNE not taken, BEQ not taken
        add(BR,3'b000,0,1,1,W_FR); add(BR,3'b000,0,1,1,W_DEC);
        add(BR,3'b000,0,1,1,cw(1,1,0,0,0,0,0,2'b10,2'b00,4'b1000,2'b00,1,0));
        add(BR,3'b001,0,1,1,W_FR); add(BR,3'b001,0,1,1,W_DEC);
        add(BR,3'b001,0,1,1,cw(0,1,0,0,0,0,0,2'b10,2'b00,4'b1000,2'b00,1,0));
        add(BR,3'b000,0,0,1,W_FR); add(BR,3'b000,0,0,1,W_DEC);
        add(BR,3'b000,0,0,1,cw(0,1,0,0,0,0,0,2'b10,2'b00,4'b1000,2'b00,1,0));
        // JAL, LUI
        add(JL,3'b000,0,0,1,W_FR); add(JL,3'b000,0,0,1,W_DEC); add(JL,3'b000,0,0,1,W_JAL);
        add(LU,3'b000,0,0,1,W_FR); add(LU,3'b000,0,0,1,W_DEC); add(LU,3'b000,0,0,1,W_LUI);

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("reset_ctl", {13'd0, ctl}, 32'd0);
        chk("reset_instret", instret, 32'd0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            cyc($sformatf("vec%0d", i), tbl[i].op, tbl[i].f3, tbl[i].f7,
                tbl[i].z, tbl[i].rdy, tbl[i].exp);
            if (tbl[i].exp[1]) exp_ret++;
        end
        chk("instret_table", instret, exp_ret);

        // Counter wrap through a LUI
        dut.instret_q = 32'hFFFF_FFFF;
        cyc("wrap_f", LU,3'b000,0,0,1,W_FR);
        cyc("wrap_d", LU,3'b000,0,0,1,W_DEC);
        cyc("wrap_lui", LU,3'b000,0,0,1,W_LUI);
        chk("instret_wrap", instret, 32'd0);

        // JAL then a store stalled by reset
        cyc("jal_f", JL,3'b000,0,0,1,W_FR);
        cyc("jal_d", JL,3'b000,0,0,1,W_DEC);
        cyc("jal_x", JL,3'b000,0,0,1,W_JAL);
        chk("instret_jal", instret, 32'd1);
        cyc("st_f", ST,3'b000,0,0,1,W_FR);
        cyc("st_d", ST,3'b000,0,0,1,W_DEC);
        cyc("st_a", ST,3'b000,0,0,1,W_MA);
        cyc("st_w0", ST,3'b000,0,0,0,W_SW);
        mem_ready = 1'b0;
        #1 chk("st_w1", {13'd0, ctl}, {13'd0, W_SW});
        #1 rst = 1'b0;
        #1 chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc("post_rst_fetch", ST,3'b000,0,0,0,W_FW);

        // Illegal opcode: trap held, no memory traffic, cleared by reset
        cyc("ill_f", 7'b0000000,3'b000,0,0,1,W_FR);
        cyc("ill_d", 7'b0000000,3'b000,0,0,1,W_DEC);
        for (int k = 0; k < 100; k++)
            cyc($sformatf("ill_hold%0d", k), 7'b0000000,3'b000,0,0,k[0],W_TRAP);
        chk("ill_instret", instret, 32'd0);
        rst = 1'b0;
        #1 chk("ill_rst", {13'd0, ctl}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Unsupported branch encoding traps after an output-free BRANCH cycle
        cyc("bill_f", BR,3'b100,0,1,1,W_FR);
        cyc("bill_d", BR,3'b100,0,1,1,W_DEC);
        cyc("bill_b", BR,3'b100,0,1,1,19'd0);
        cyc("bill_t0", BR,3'b100,0,1,1,W_TRAP);
        cyc("bill_t1", BR,3'b100,0,1,0,W_TRAP);
        chk("bill_instret", instret, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
